lab_color_remap: RTL and testbench
==================================

# lab_color_remap

Per-pixel remap stage that sits downstream of the Lab statistics pass. It takes the source and target per-channel means and standard deviations and computes the three scale ratios t_std/s_std with a sequential divider. It then streams source Lab pixels through a 2-stage pipeline that applies out = (in − s_mean)·ratio + t_mean with clamping, and hands the results to the SRAM write-back logic over a valid/ready interface.

## Interface
- FRAC, 8, fractional bits of each ratio (ratio = round-down((t_std << FRAC) / s_std))
- RATIO_W, 16, ratio width in bits (unsigned)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- start  in  1  one-cycle pulse; latches the statistics and the pixel count; honoured only in IDLE
- iS_mean  in  24  source means {L[23:16], A[15:8], B[7:0]}, unsigned
- iT_mean  in  24  target means, same packing
- iS_std  in  24  source std devs, same packing
- iT_std  in  24  target std devs, same packing
- iPixel_Count  in  20  number of pixels to process
- oReady  out  1  high while in RUN
- oDone  out  1  one-cycle pulse when the last pixel has been output
- in_valid  in  1  input pixel valid
- in_ready  out  1  input pixel accepted when in_valid && in_ready
- in_pixel  in  24  source Lab pixel {L,A,B}
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts
- out_pixel  out  24  remapped Lab pixel {L,A,B}

## Operation
- States: IDLE → DIV → RUN → IDLE.
- IDLE:
  - start latches iS_mean, iT_mean, iS_std, iT_std and iPixel_Count, clears the accepted and emitted counters, and moves to DIV.
  - start in any other state is ignored.
- DIV:
  - Restoring divider, one quotient bit per cycle, channels in order L, A, B.
  - 16 cycles per channel, 48 cycles total.
  - Dividend is t_std << FRAC; divisor is s_std.
  - If s_std == 0, the ratio is 1 << FRAC (identity); the cycle count is unchanged.
  - Maximum quotient is 65280, so no saturation is needed.
  - After the B channel completes → RUN, or straight back to IDLE with oDone pulsed when the latched count is 0.
- RUN datapath, per channel:
  - Stage 1: d = in − s_mean, signed 9-bit; p = d · ratio, signed 26-bit.
  - Stage 2: q = (p + (1 << (FRAC−1))) >>> FRAC (arithmetic shift, round half up); r = q + t_mean; clamp r to 0..255.
- Pipeline flow:
  - advance = !out_valid || out_ready.
  - Both stages move only on advance; a bubble may enter on advance.
  - in_ready = RUN && advance && (accepted < count).
- Counting:
  - accepted increments on each input handshake; emitted increments on each output handshake.
  - When emitted reaches count on a handshake: oDone is pulsed the next cycle and the state returns to IDLE.
- out_pixel holds stable while out_valid && !out_ready.
- Reset, at any time including mid-DIV or mid-RUN:
  - state = IDLE; counters, ratios and pipeline valids cleared.
  - Outputs: oReady=0, oDone=0, in_ready=0, out_valid=0, out_pixel=0.
  - Pixels in flight are dropped.

## Timing
- start sampled at edge T → state is DIV from T+1; ratios valid and RUN entered at T+49.
- oReady and in_ready can first be high in cycle T+49.
- Latency with out_ready held high: pixel accepted at edge E → out_valid with the result from E+2.
- Throughput is 1 pixel/cycle with no backpressure.
- out_ready low: the pipeline freezes, in_ready drops in the same cycle (combinational), and no pixel is lost or duplicated.
- Input and output handshakes in the same cycle are both legal.
- Last output handshake at edge F → oDone high for the cycle after F; state IDLE; a new start is accepted from that cycle.

## Test plan
- Identity:
  - Stimulus: all means 128, all stds 40 (ratio 256), count 1, pixel 0x1020F0.
  - Required: out_pixel 0x1020F0, 2 cycles after the input handshake; oDone once.
- Scaling and rounding:
  - Stimulus: L s_std 20 / t_std 40 (ratio 512), s_mean 100, t_mean 120, L in 110.
  - Required: L out 140.
  - Stimulus: A s_std 2 / t_std 3 (ratio 384), means 0, A in 1.
  - Required: A out 2 (0 when A in is 0).
- Clamping:
  - Stimulus: ratio 512, s_mean 100, t_mean 120.
  - Required: L in 250 → 255; L in 0 → 0.
- Zero std:
  - Stimulus: s_std 0 on all channels, t_std 50.
  - Required: ratio 256; in equals out when means are equal; DIV still lasts exactly 48 cycles.
- Backpressure:
  - Stimulus: stream 6 pixels with out_ready low for 5 cycles mid-stream.
  - Required: all 6 outputs in order with no duplicates; in_ready low whenever out_valid && !out_ready.
- Count, done and reset:
  - Count 0 → oDone at T+49 with no in_ready ever high.
  - rst asserted mid-RUN → all outputs 0 next cycle; a fresh start completes normally.

Source files
------------

// File: rtl/lab_color_remap.sv
`default_nettype none
// ============================================================================
// Module   : lab_color_remap
// Brief    : Lab colour-transfer remap stage. It derives t_std/s_std ratios with
//            a restoring divider, then runs a 2-stage scale/offset/clamp pipeline.
// Revision : 1.0
// ============================================================================
module lab_color_remap #(
    parameter int FRAC    = 8,
    parameter int RATIO_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] iS_mean,
    input  logic [23:0] iT_mean,
    input  logic [23:0] iS_std,
    input  logic [23:0] iT_std,
    input  logic [19:0] iPixel_Count,
    output logic        oReady,
    output logic        oDone,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_pixel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_pixel
);

    localparam int c_dvd_w = 8 + FRAC;
    localparam int c_bit_w = $clog2(c_dvd_w);
    localparam int c_p_w   = 10 + RATIO_W;
    localparam int c_q_w   = c_p_w - FRAC;
    localparam int c_r_w   = c_q_w + 1;
    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(c_dvd_w - 1);
    localparam logic signed [c_p_w-1:0] c_half = c_p_w'(1 << (FRAC - 1));

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_div  = 2'd1;
    localparam logic [1:0] c_st_run  = 2'd2;

    logic [1:0]         r_state;
    logic [23:0]        r_s_mean;
    logic [23:0]        r_t_mean;
    logic [23:0]        r_s_std;
    logic [15:0]        r_t_std_ab;
    logic [19:0]        r_count;
    logic [19:0]        r_accepted;
    logic [19:0]        r_emitted;
    logic               r_done;
    logic [RATIO_W-1:0] r_ratio [3];

    logic [1:0]         r_ch;
    logic [c_bit_w-1:0] r_bit;
    logic [c_dvd_w-1:0] r_dvd;
    logic [c_dvd_w-1:0] r_quo;
    logic [7:0]         r_rem;

    logic               r_s1_valid;
    logic               r_out_valid;
    logic [23:0]        r_out_pixel;

    logic               w_advance;
    logic               w_in_fire;
    logic               w_out_fire;
    logic [7:0]         w_div_s;
    logic [7:0]         w_t_next;
    logic [8:0]         w_trial;
    logic               w_ge;
    logic [8:0]         w_rem_nxt;
    logic [c_dvd_w-1:0] w_quo_nxt;
    logic [RATIO_W-1:0] w_ratio_new;
    logic [23:0]        w_res;

    assign w_advance  = !r_out_valid || out_ready;
    assign in_ready   = (r_state == c_st_run) && w_advance && (r_accepted < r_count);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    assign oReady    = (r_state == c_st_run);
    assign oDone     = r_done;
    assign out_valid = r_out_valid;
    assign out_pixel = r_out_pixel;

    always_comb begin
        w_div_s  = r_s_std[7:0];
        w_t_next = r_t_std_ab[7:0];
        case (r_ch)
            2'd0: begin
                w_div_s  = r_s_std[23:16];
                w_t_next = r_t_std_ab[15:8];
            end
            2'd1: w_div_s = r_s_std[15:8];
            default: w_div_s = r_s_std[7:0];
        endcase
    end

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    assign w_trial     = {r_rem, r_dvd[c_dvd_w-1]};
    assign w_ge        = (w_trial >= {1'b0, w_div_s});
    assign w_rem_nxt   = w_ge ? (w_trial - {1'b0, w_div_s}) : w_trial;
    assign w_quo_nxt   = c_dvd_w'({r_quo, w_ge});
    assign w_ratio_new = (w_div_s == 8'd0) ? RATIO_W'(1 << FRAC) : RATIO_W'(w_quo_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_s_mean   <= '0;
            r_t_mean   <= '0;
            r_s_std    <= '0;
            r_t_std_ab <= '0;
            r_count    <= '0;
            r_accepted <= '0;
            r_emitted  <= '0;
            r_done     <= 1'b0;
            r_ratio[0] <= '0;
            r_ratio[1] <= '0;
            r_ratio[2] <= '0;
            r_ch       <= '0;
            r_bit      <= '0;
            r_dvd      <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_s_mean   <= iS_mean;
                        r_t_mean   <= iT_mean;
                        r_s_std    <= iS_std;
                        r_t_std_ab <= iT_std[15:0];
                        r_count    <= iPixel_Count;
                        r_accepted <= '0;
                        r_emitted  <= '0;
                        r_ch       <= '0;
                        r_bit      <= '0;
                        r_rem      <= '0;
                        r_quo      <= '0;
                        r_dvd      <= {iT_std[23:16], {FRAC{1'b0}}};
                        r_state    <= c_st_div;
                    end
                end
                c_st_div: begin
                    r_dvd <= r_dvd << 1;
                    r_rem <= 8'(w_rem_nxt);
                    r_quo <= w_quo_nxt;
                    r_bit <= r_bit + 1'b1;
                    if (r_bit == c_last_bit) begin
                        case (r_ch)
                            2'd0:    r_ratio[0] <= w_ratio_new;
                            2'd1:    r_ratio[1] <= w_ratio_new;
                            default: r_ratio[2] <= w_ratio_new;
                        endcase
                        r_ch  <= r_ch + 2'd1;
                        r_bit <= '0;
                        r_rem <= '0;
                        r_quo <= '0;
                        r_dvd <= {w_t_next, {FRAC{1'b0}}};
                        if (r_ch == 2'd2) begin
                            if (r_count == 20'd0) begin
                                r_state <= c_st_idle;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= c_st_run;
                            end
                        end
                    end
                end
                c_st_run: begin
                    if (w_in_fire)
                        r_accepted <= r_accepted + 20'd1;
                    if (w_out_fire) begin
                        r_emitted <= r_emitted + 20'd1;
                        if (r_emitted + 20'd1 == r_count) begin
                            r_state <= c_st_idle;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Stage 1 captures the signed product; stage 2 rounds, offsets and clamps.
    for (genvar i = 0; i < 3; i++) begin : g_ch
        localparam int c_lsb = 16 - 8 * i;
        logic signed [8:0]       w_d;
        logic signed [c_p_w-1:0] w_p;
        logic signed [c_p_w-1:0] r_p;
        logic signed [c_p_w-1:0] w_p_rnd;
        logic signed [c_q_w-1:0] w_q;
        logic signed [c_r_w-1:0] w_r;

        assign w_d = $signed({1'b0, in_pixel[c_lsb +: 8]}) - $signed({1'b0, r_s_mean[c_lsb +: 8]});
        assign w_p = c_p_w'(w_d) * c_p_w'($signed({1'b0, r_ratio[i]}));

        always_ff @(posedge clk) begin
            if (rst)
                r_p <= '0;
            else if (w_in_fire)
                r_p <= w_p;
        end

        assign w_p_rnd = r_p + c_half;
        assign w_q     = c_q_w'(w_p_rnd >>> FRAC);
        assign w_r     = $signed({w_q[c_q_w-1], w_q}) +
                         $signed({{(c_r_w-8){1'b0}}, r_t_mean[c_lsb +: 8]});
        assign w_res[c_lsb +: 8] = w_r[c_r_w-1] ? 8'd0 :
                                   (|w_r[c_r_w-2:8]) ? 8'hFF : w_r[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_pixel <= '0;
        end else if (w_advance) begin
            r_s1_valid  <= w_in_fire;
            r_out_valid <= r_s1_valid;
            if (r_s1_valid)
                r_out_pixel <= w_res;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lab_color_remap.sv
`default_nettype none
// ============================================================================
// Module   : tb_lab_color_remap
// Brief    : Scoreboard bench for lab_color_remap: per-scenario tasks, expected
//            pixels queued at input handshake and compared at output handshake.
// Revision : 1.0
// ============================================================================
module tb_lab_color_remap;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] iS_mean, iT_mean, iS_std, iT_std;
    logic [19:0] iPixel_Count;
    logic        oReady, oDone;
    logic        in_valid, in_ready;
    logic [23:0] in_pixel;
    logic        out_valid, out_ready;
    logic [23:0] out_pixel;

    int checks = 0;
    int errors = 0;

    logic [23:0] sb[$];
    int          sb_cyc[$];
    logic [23:0] out_log[$];
    logic [23:0] px[$];
    int          bp_start, bp_len;
    int          m_ratio[3];
    logic [23:0] m_sm, m_tm;

    always #5 clk = ~clk;

    lab_color_remap dut (
        .clk(clk), .rst(rst), .start(start),
        .iS_mean(iS_mean), .iT_mean(iT_mean), .iS_std(iS_std), .iT_std(iT_std),
        .iPixel_Count(iPixel_Count), .oReady(oReady), .oDone(oDone),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel)
    );

    function automatic logic [23:0] model(input logic [23:0] p_in);
        logic [23:0] res;
        res = '0;
        for (int c = 0; c < 3; c++) begin
            int     sh;
            longint d, p, q, r;
            sh = 16 - 8 * c;
            d  = longint'(p_in[sh +: 8]) - longint'(m_sm[sh +: 8]);
            p  = d * longint'(m_ratio[c]);
            q  = (p + 128) >>> 8;
            r  = q + longint'(m_tm[sh +: 8]);
            if (r < 0) r = 0;
            if (r > 255) r = 255;
            res[sh +: 8] = 8'(r);
        end
        return res;
    endfunction

    task automatic start_job(input logic [23:0] sm, tm, ss, ts, input logic [19:0] cnt,
                             output int n, output int saw_rdy);
        for (int c = 0; c < 3; c++) begin
            int s, t;
            s = int'(ss[16 - 8 * c +: 8]);
            t = int'(ts[16 - 8 * c +: 8]);
            m_ratio[c] = (s == 0) ? 256 : (t * 256) / s;
        end
        m_sm = sm;
        m_tm = tm;
        @(negedge clk);
        iS_mean = sm; iT_mean = tm; iS_std = ss; iT_std = ts;
        iPixel_Count = cnt;
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        n       = 1;
        saw_rdy = 0;
        while (!oReady && !oDone && n < 100) begin
            if (in_ready) saw_rdy = 1;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_pixels(output int emitted);
        int sent, cyc, viol, c0;
        logic [23:0] e_pix;
        sent = 0; cyc = 0; viol = 0; emitted = 0;
        out_log.delete();
        while (emitted < px.size() && cyc < 300) begin
            in_valid  = (sent < px.size());
            in_pixel  = in_valid ? px[sent] : 24'h0;
            out_ready = !(cyc >= bp_start && cyc < bp_start + bp_len);
            #1;
            if (out_valid && !out_ready && in_ready) viol++;
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow got %h with no pixel outstanding", out_pixel);
                end else begin
                    e_pix = sb.pop_front();
                    c0    = sb_cyc.pop_front();
                    out_log.push_back(out_pixel);
                    if (out_pixel !== e_pix) begin
                        errors++;
                        $display("FAIL out_pixel got %h exp %h", out_pixel, e_pix);
                    end
                    if (bp_len == 0) begin
                        checks++;
                        if (cyc - c0 !== 2) begin
                            errors++;
                            $display("FAIL latency got %0d exp 2", cyc - c0);
                        end
                    end
                end
                emitted++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(in_pixel));
                sb_cyc.push_back(cyc);
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (emitted != px.size()) begin
            errors++;
            $display("FAIL stream_timeout got %0d outputs exp %0d", emitted, px.size());
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL in_ready_backpressure got %0d violations exp 0", viol);
        end
        checks++;
        if (oDone !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse got %b exp 1", oDone);
        end
        checks++;
        if (oReady !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_done oReady got %b exp 0", oReady);
        end
        @(negedge clk);
        #1;
        checks++;
        if (oDone !== 1'b0) begin
            errors++;
            $display("FAIL done_single got %b exp 0", oDone);
        end
    endtask

    task automatic check_ready_cycle(input int n);
        checks++;
        if (n !== 49) begin
            errors++;
            $display("FAIL div_cycles got %0d exp 49", n);
        end
    endtask

    task automatic check_out_log(input int idx, input logic [23:0] e);
        checks++;
        if (out_log.size() <= idx) begin
            errors++;
            $display("FAIL out_log_missing idx %0d got none exp %h", idx, e);
        end else if (out_log[idx] !== e) begin
            errors++;
            $display("FAIL out_const idx %0d got %h exp %h", idx, out_log[idx], e);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if ({oReady, oDone, in_ready, out_valid, out_pixel} !== 28'h0) begin
            errors++;
            $display("FAIL %s got rdy=%b done=%b in_rdy=%b ov=%b pix=%h exp all 0",
                     tag, oReady, oDone, in_ready, out_valid, out_pixel);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b1;
        iS_mean = '0; iT_mean = '0; iS_std = '0; iT_std = '0; iPixel_Count = '0;
        bp_start = 0; bp_len = 0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset_state");
        rst = 1'b0;
    endtask

    task automatic test_identity();
        int n, s, e;
        start_job(24'h808080, 24'h808080, 24'h282828, 24'h282828, 20'd1, n, s);
        check_ready_cycle(n);
        px = '{24'h1020F0};
        bp_len = 0;
        run_pixels(e);
        check_out_log(0, 24'h1020F0);
    endtask

    task automatic test_scaling();
        int n, s, e;
        start_job(24'h640000, 24'h780000, 24'h140201, 24'h280301, 20'd2, n, s);
        px = '{24'h6E0100, 24'h6E0005};
        bp_len = 0;
        run_pixels(e);
        check_out_log(0, 24'h8C0200);
        check_out_log(1, 24'h8C0005);
    endtask

    task automatic test_clamp();
        int n, s, e;
        start_job(24'h640000, 24'h780000, 24'h140201, 24'h280301, 20'd2, n, s);
        px = '{24'hFA0000, 24'h000000};
        bp_len = 0;
        run_pixels(e);
        check_out_log(0, 24'hFF0000);
        check_out_log(1, 24'h000000);
    endtask

    task automatic test_zero_std();
        int n, s, e;
        start_job(24'h405060, 24'h405060, 24'h000000, 24'h323232, 20'd3, n, s);
        check_ready_cycle(n);
        px = '{24'hA0B0C0, 24'h000000, 24'hFFFFFF};
        bp_len = 0;
        run_pixels(e);
        check_out_log(0, 24'hA0B0C0);
        check_out_log(1, 24'h000000);
        check_out_log(2, 24'hFFFFFF);
    endtask

    task automatic test_backpressure();
        int n, s, e;
        start_job(24'h7F3050, 24'h8060A0, 24'h102030, 24'h203010, 20'd6, n, s);
        px = '{24'h112233, 24'h8090A0, 24'hFF00FF, 24'h00FF00, 24'h7F7F7F, 24'h4080C0};
        bp_start = 3;
        bp_len   = 5;
        run_pixels(e);
        bp_len = 0;
    endtask

    task automatic test_count_zero();
        int n, s;
        start_job(24'h808080, 24'h808080, 24'h282828, 24'h282828, 20'd0, n, s);
        check_ready_cycle(n);
        checks++;
        if (oDone !== 1'b1 || oReady !== 1'b0) begin
            errors++;
            $display("FAIL count0_done got done=%b rdy=%b exp done=1 rdy=0", oDone, oReady);
        end
        checks++;
        if (s != 0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL count0_in_ready got seen=%0d now=%b exp 0", s, in_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (oDone !== 1'b0) begin
            errors++;
            $display("FAIL count0_done_single got %b exp 0", oDone);
        end
    endtask

    task automatic test_reset_mid_run();
        int n, s, e;
        start_job(24'h808080, 24'h808080, 24'h282828, 24'h282828, 20'd4, n, s);
        in_valid  = 1'b1;
        in_pixel  = 24'h1020F0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrun_stalled out_valid got %b exp 1", out_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_idle_outputs("midrun_reset");
        rst = 1'b0;
        out_ready = 1'b1;
        sb.delete();
        sb_cyc.delete();
        start_job(24'h808080, 24'h808080, 24'h282828, 24'h282828, 20'd2, n, s);
        check_ready_cycle(n);
        px = '{24'h1020F0, 24'h336699};
        bp_len = 0;
        run_pixels(e);
        check_out_log(1, 24'h336699);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_scaling();
        test_clamp();
        test_zero_std();
        test_backpressure();
        test_count_zero();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
